// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer: update kinds,
// default geometry and saturating counter helpers.
package branch_target_buffer_pkg;

  localparam int unsigned DEF_ENTRIES = 16;
  localparam int unsigned DEF_CTR_W   = 2;

  typedef enum logic [1:0] {
    KIND_BR  = 2'b00,  // conditional branch (beq/bne)
    KIND_J   = 2'b01,  // direct jump (j/jal)
    KIND_JR  = 2'b10,  // indirect jump (jr/jalr)
    KIND_RSV = 2'b11   // reserved, ignored
  } upd_kind_e;

  // All-ones value of a w-bit counter, w in 1..32.
  function automatic logic [31:0] ctr_max(input int unsigned w);
    return 32'hFFFF_FFFF >> (32 - w);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    return (v >= ctr_max(w)) ? v : v + 32'd1;
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] v, input int unsigned w);
    return (v == 32'd0) ? v : v - 32'd1;
  endfunction

endpackage

// File: rtl/branch_target_buffer_sat_counter.sv
// Saturating up/down direction counter with synchronous load.
module bp_sat_counter
  import branch_target_buffer_pkg::*;
#(
  parameter int unsigned CTR_W = DEF_CTR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  output logic [CTR_W-1:0] value
);

  // Load has priority over counting; inc and dec are never both set.
  always_ff @(posedge clk) begin
    if (reset)     value <= '0;
    else if (load) value <= load_val;
    else if (inc)  value <= CTR_W'(sat_inc(32'(value), CTR_W));
    else if (dec)  value <= CTR_W'(sat_dec(32'(value), CTR_W));
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with zero-latency lookup, EX-stage
// update/mispredict detection and saturating performance counters.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int unsigned ENTRIES = DEF_ENTRIES,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned CTR_W   = DEF_CTR_W,
  parameter int unsigned STAT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bp_enable,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [1:0]        upd_kind,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_hits,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tags    [ENTRIES];
  logic [ADDR_W-3:0]  targets [ENTRIES];
  logic [CTR_W-1:0]   ctrs    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic [CTR_W-1:0] lk_ctr;
  logic             upd_hit;
  upd_kind_e        kind;

  assign lk_idx  = lookup_pc[IDX_W+1:2];
  assign lk_tag  = lookup_pc[ADDR_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];
  assign kind    = upd_kind_e'(upd_kind);
  assign lk_ctr  = ctrs[lk_idx];
  assign upd_hit = valid[upd_idx] & (tags[upd_idx] == upd_tag);

  // Counter MSB set is the same as being at or above the weakly-taken value.
  assign pred_hit    = lookup_valid & valid[lk_idx] & (tags[lk_idx] == lk_tag);
  assign pred_taken  = bp_enable & pred_hit & (lk_ctr >= CTR_WEAK);
  assign pred_target = pred_taken ? {targets[lk_idx], 2'b00} : lookup_pc + ADDR_W'(4);

  assign mispredict  = upd_valid & (kind != KIND_RSV) &
                       ((upd_pred_taken != upd_taken) |
                        (upd_taken & (upd_pred_target != upd_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + ADDR_W'(4);

  logic             alloc, wr_target, inval, ctr_inc, ctr_dec, ctr_load;
  logic [CTR_W-1:0] ctr_load_val;

  // Decode the resolved instruction into entry write controls.
  always_comb begin
    alloc        = 1'b0;
    wr_target    = 1'b0;
    inval        = 1'b0;
    ctr_inc      = 1'b0;
    ctr_dec      = 1'b0;
    ctr_load     = 1'b0;
    ctr_load_val = '0;
    if (upd_valid) begin
      case (kind)
        KIND_BR: begin
          if (upd_hit) begin
            ctr_inc   = upd_taken;
            ctr_dec   = ~upd_taken;
            wr_target = upd_taken;
          end else if (upd_taken) begin
            alloc        = 1'b1;
            ctr_load     = 1'b1;
            ctr_load_val = CTR_WEAK;
          end
        end
        KIND_J: begin
          alloc        = 1'b1;
          ctr_load     = 1'b1;
          ctr_load_val = '1;
        end
        KIND_JR:  inval = upd_hit;
        default: ;
      endcase
    end
  end

  // Entry valid/tag/target storage; reset wins over a same-cycle update.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tags[i]    <= '0;
        targets[i] <= '0;
      end
    end else begin
      if (alloc) begin
        valid[upd_idx] <= 1'b1;
        tags[upd_idx]  <= upd_tag;
      end
      if (alloc | wr_target) targets[upd_idx] <= upd_target[ADDR_W-1:2];
      if (inval) valid[upd_idx] <= 1'b0;
    end
  end

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ctr
    logic sel;
    assign sel = (upd_idx == IDX_W'(e));
    bp_sat_counter #(.CTR_W(CTR_W)) u_ctr (
      .clk      (clk),
      .reset    (reset),
      .inc      (ctr_inc & sel),
      .dec      (ctr_dec & sel),
      .load     (ctr_load & sel),
      .load_val (ctr_load_val),
      .value    (ctrs[e])
    );
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_lookups     <= '0;
      stat_hits        <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (lookup_valid && stat_lookups != '1)   stat_lookups     <= stat_lookups + 1'b1;
      if (pred_hit && stat_hits != '1)          stat_hits        <= stat_hits + 1'b1;
      if (mispredict && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed, table-driven bench for branch_target_buffer (ENTRIES=16, STAT_W=4).
module tb_branch_target_buffer;

  localparam logic [1:0] K_BR = 2'b00, K_J = 2'b01, K_JR = 2'b10, K_RSV = 2'b11;

  logic        clk = 1'b0;
  logic        reset, bp_enable, lookup_valid, upd_valid, upd_taken, upd_pred_taken;
  logic [1:0]  upd_kind;
  logic [31:0] lookup_pc, upd_pc, upd_target, upd_pred_target;
  logic        pred_hit, pred_taken, mispredict;
  logic [31:0] pred_target, redirect_pc;
  logic [3:0]  stat_lookups, stat_hits, stat_mispredicts;

  branch_target_buffer #(.ENTRIES(16), .ADDR_W(32), .CTR_W(2), .STAT_W(4)) dut (
    .clk(clk), .reset(reset), .bp_enable(bp_enable),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_kind(upd_kind), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_lookups(stat_lookups), .stat_hits(stat_hits),
    .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        bp, lv;
    logic [31:0] lpc;
    logic        uv;
    logic [1:0]  kind;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        upt;
    logic [31:0] uptgt;
    logic        e_hit, e_taken;
    logic [31:0] e_tgt;
    logic        e_mis;
    logic [31:0] e_redir;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [3:0] m_lk, m_hit, m_mis;

  function automatic void vec(logic bp, logic lv, logic [31:0] lpc, logic uv, logic [1:0] kind,
                              logic [31:0] upc, logic ut, logic [31:0] utgt, logic upt,
                              logic [31:0] uptgt, logic e_hit, logic e_taken,
                              logic [31:0] e_tgt, logic e_mis, logic [31:0] e_redir);
    vec_t v;
    v.bp = bp; v.lv = lv; v.lpc = lpc; v.uv = uv; v.kind = kind; v.upc = upc;
    v.ut = ut; v.utgt = utgt; v.upt = upt; v.uptgt = uptgt;
    v.e_hit = e_hit; v.e_taken = e_taken; v.e_tgt = e_tgt; v.e_mis = e_mis; v.e_redir = e_redir;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_upd();
    upd_valid = 0; upd_kind = K_BR; upd_pc = '0; upd_taken = 0;
    upd_target = '0; upd_pred_taken = 0; upd_pred_target = '0;
  endtask

  function automatic logic [3:0] sat4(logic [3:0] v, logic en);
    return (en && v != 4'hF) ? v + 4'd1 : v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // table: bp lv lpc | uv kind upc ut utgt upt uptgt | hit taken tgt mis redir
    vec(1,1,32'h00400010, 0,K_BR,0,0,0,0,0,                                    0,0,32'h00400014, 0,0);
    vec(1,0,32'h00400010, 1,K_BR,32'h00400010,1,32'h00400040,0,32'h00400014,   0,0,32'h00400014, 1,32'h00400040);
    vec(1,1,32'h00400010, 0,K_BR,0,0,0,0,0,                                    1,1,32'h00400040, 0,0);
    vec(1,1,32'h00400010, 1,K_BR,32'h00400010,0,32'h00400040,1,32'h00400040,   1,1,32'h00400040, 1,32'h00400014);
    vec(1,1,32'h00400010, 1,K_BR,32'h00400010,0,0,0,32'h00400014,              1,0,32'h00400014, 0,32'h00400014);
    vec(1,1,32'h00400010, 1,K_BR,32'h00400010,0,0,0,32'h00400014,              1,0,32'h00400014, 0,32'h00400014);
    vec(1,1,32'h00400010, 0,K_BR,0,0,0,0,0,                                    1,0,32'h00400014, 0,0);
    vec(1,1,32'h00400010, 1,K_BR,32'h00400010,1,32'h00400040,0,32'h00400014,   1,0,32'h00400014, 1,32'h00400040);
    vec(1,1,32'h00400010, 1,K_BR,32'h00400010,1,32'h00400040,0,32'h00400014,   1,0,32'h00400014, 1,32'h00400040);
    vec(0,1,32'h00400010, 0,K_BR,0,0,0,0,0,                                    1,0,32'h00400014, 0,0);
    vec(1,1,32'h00400010, 1,K_J,32'h00400050,1,32'h00400100,0,32'h00400014,    1,1,32'h00400040, 1,32'h00400100);
    vec(1,1,32'h00400010, 1,K_J,32'h00400050,1,32'h00400100,1,32'h00400100,    0,0,32'h00400014, 0,32'h00400100);
    vec(1,1,32'h00400050, 1,K_BR,32'h00400050,0,0,1,32'h00400100,              1,1,32'h00400100, 1,32'h00400054);
    vec(1,1,32'h00400050, 1,K_RSV,32'h00400050,0,0,1,32'h00400100,             1,1,32'h00400100, 0,32'h00400054);
    vec(1,1,32'h00400050, 1,K_JR,32'h00400050,1,32'h00400200,1,32'h00400100,   1,1,32'h00400100, 1,32'h00400200);
    vec(1,1,32'h00400050, 1,K_JR,32'h00400050,1,32'h00400200,0,32'h00400054,   0,0,32'h00400054, 1,32'h00400200);
    vec(1,1,32'h00400050, 0,K_BR,0,0,0,0,0,                                    0,0,32'h00400054, 0,0);
    vec(1,1,32'h00400050, 1,K_J,32'h80400050,1,32'h80000180,0,32'h80400054,    0,0,32'h00400054, 1,32'h80000180);
    vec(1,1,32'h00400050, 0,K_BR,0,0,0,0,0,                                    0,0,32'h00400054, 0,0);
    vec(1,1,32'h80400050, 0,K_BR,0,0,0,0,0,                                    1,1,32'h80000180, 0,0);
    vec(1,1,32'hFFFFFFFC, 1,K_BR,32'hFFFFFFFC,0,0,0,0,                         0,0,32'h00000000, 0,32'h00000000);
    vec(1,1,32'hFFFFFFFC, 0,K_BR,0,0,0,0,0,                                    0,0,32'h00000000, 0,0);

    reset = 1; bp_enable = 1; lookup_valid = 0; lookup_pc = '0; idle_upd();
    repeat (2) @(posedge clk);
    m_lk = '0; m_hit = '0; m_mis = '0;

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = 0;
      bp_enable = vecs[i].bp; lookup_valid = vecs[i].lv; lookup_pc = vecs[i].lpc;
      upd_valid = vecs[i].uv; upd_kind = vecs[i].kind; upd_pc = vecs[i].upc;
      upd_taken = vecs[i].ut; upd_target = vecs[i].utgt;
      upd_pred_taken = vecs[i].upt; upd_pred_target = vecs[i].uptgt;
      #2;
      chk($sformatf("v%0d pred_hit", i), 32'(pred_hit), 32'(vecs[i].e_hit));
      chk($sformatf("v%0d pred_taken", i), 32'(pred_taken), 32'(vecs[i].e_taken));
      chk($sformatf("v%0d pred_target", i), pred_target, vecs[i].e_tgt);
      chk($sformatf("v%0d mispredict", i), 32'(mispredict), 32'(vecs[i].e_mis));
      if (vecs[i].uv) chk($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].e_redir);
      chk($sformatf("v%0d stat_lookups", i), 32'(stat_lookups), 32'(m_lk));
      chk($sformatf("v%0d stat_hits", i), 32'(stat_hits), 32'(m_hit));
      chk($sformatf("v%0d stat_mispredicts", i), 32'(stat_mispredicts), 32'(m_mis));
      m_lk  = sat4(m_lk, vecs[i].lv);
      m_hit = sat4(m_hit, vecs[i].e_hit);
      m_mis = sat4(m_mis, vecs[i].e_mis);
    end

    // Reset in the same cycle as a jump update: entry must not be written.
    @(negedge clk);
    reset = 1; lookup_valid = 0; lookup_pc = '0;
    upd_valid = 1; upd_kind = K_J; upd_pc = 32'h00400030; upd_taken = 1;
    upd_target = 32'h00400300; upd_pred_taken = 0; upd_pred_target = '0;
    @(negedge clk);
    reset = 0; idle_upd(); lookup_valid = 1; lookup_pc = 32'h00400030;
    #2;
    chk("rst_upd hit", 32'(pred_hit), 32'd0);
    chk("rst_upd target", pred_target, 32'h00400034);
    chk("rst stat_mispredicts", 32'(stat_mispredicts), 32'd0);
    chk("rst stat_lookups", 32'(stat_lookups), 32'd0);
    @(negedge clk);
    lookup_pc = 32'h80400050;
    #2;
    chk("rst clears entry hit", 32'(pred_hit), 32'd0);
    chk("rst stat_lookups after 1", 32'(stat_lookups), 32'd1);

    // Mispredict counter saturation at 4'hF.
    lookup_valid = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      upd_valid = 1; upd_kind = K_BR; upd_pc = 32'h00400060; upd_taken = 1;
      upd_target = 32'h00400400; upd_pred_taken = 0; upd_pred_target = 32'h00400064;
      #2;
      chk($sformatf("sat%0d mispredict", k), 32'(mispredict), 32'd1);
      chk($sformatf("sat%0d stat_mispredicts", k), 32'(stat_mispredicts), (k < 15) ? 32'(k) : 32'd15);
    end
    @(negedge clk);
    idle_upd(); lookup_valid = 1; lookup_pc = 32'h00400060;
    #2;
    chk("sat final stat_mispredicts", 32'(stat_mispredicts), 32'd15);
    chk("sat entry hit", 32'(pred_hit), 32'd1);
    chk("sat entry target", pred_target, 32'h00400400);
    chk("sat stat_hits", 32'(stat_hits), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
